vliw_regfile: RTL and testbench

//  Shared integer register file serving every VLIW issue lane. Each lane's IXU

---
 rtl/vliw_regfile.sv | 108 ++++++++++
 tb/tb_vliw_regfile.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vliw_regfile.sv
// Shared integer register file for all VLIW issue lanes.
// Two combinational read ports and one write port per lane, same-cycle write bypass,
// highest-lane-wins resolution of same-register write collisions, and a sticky
// collision flag plus saturating collision-cycle counter.
module vliw_regfile #(
    parameter int unsigned NUM_LANES = 2,
    parameter int unsigned NUM_REGS  = 32,
    parameter int unsigned XLEN      = 32,
    parameter int unsigned CNT_W     = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_LANES*5-1:0]    rs1_addr,
    input  logic [NUM_LANES*5-1:0]    rs2_addr,
    output logic [NUM_LANES*XLEN-1:0] rs1_data,
    output logic [NUM_LANES*XLEN-1:0] rs2_data,
    input  logic [NUM_LANES*5-1:0]    wr_addr,
    input  logic [NUM_LANES*XLEN-1:0] wr_data,
    input  logic [NUM_LANES-1:0]      wr_en,
    output logic                      wr_conflict,
    output logic [CNT_W-1:0]          conflict_cnt,
    input  logic                      conflict_clr
);

    logic [XLEN-1:0]  regs_q [NUM_REGS];
    logic             conflict_q;
    logic [CNT_W-1:0] cnt_q;
    logic             collision;

    // x0 and out-of-range addresses are never stored and always read as zero.
    function automatic logic valid_addr(input logic [4:0] a);
        return (a != 5'd0) && ({27'd0, a} < NUM_REGS);
    endfunction

    // Array value with same-cycle bypass; later lanes override earlier ones so the
    // highest-numbered writer wins. Bypass is suppressed while reset is held.
    function automatic logic [XLEN-1:0] read_port(input logic [4:0] a);
        logic [XLEN-1:0] val;
        val = '0;
        if (valid_addr(a)) begin
            val = regs_q[a];
            for (int l = 0; l < NUM_LANES; l++) begin
                if (rst && wr_en[l] && (wr_addr[5*l +: 5] == a)) begin
                    val = wr_data[XLEN*l +: XLEN];
                end
            end
        end
        return val;
    endfunction

    // Detect two or more lanes writing the same valid register this cycle.
    always_comb begin
        collision = 1'b0;
        for (int i = 0; i < NUM_LANES; i++) begin
            for (int j = i + 1; j < NUM_LANES; j++) begin
                if (wr_en[i] && wr_en[j] && (wr_addr[5*i +: 5] == wr_addr[5*j +: 5]) &&
                    valid_addr(wr_addr[5*i +: 5])) begin
                    collision = 1'b1;
                end
            end
        end
    end

    // Combinational read ports for every lane.
    always_comb begin
        rs1_data = '0;
        rs2_data = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            rs1_data[XLEN*l +: XLEN] = read_port(rs1_addr[5*l +: 5]);
            rs2_data[XLEN*l +: XLEN] = read_port(rs2_addr[5*l +: 5]);
        end
    end

    // Register array; ascending lane order makes the last NBA (highest lane) win.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs_q[r] <= '0;
            end
        end else begin
            for (int l = 0; l < NUM_LANES; l++) begin
                if (wr_en[l] && valid_addr(wr_addr[5*l +: 5])) begin
                    regs_q[wr_addr[5*l +: 5]] <= wr_data[XLEN*l +: XLEN];
                end
            end
        end
    end

    // Sticky collision flag and saturating counter; clear takes priority.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            conflict_q <= 1'b0;
            cnt_q      <= '0;
        end else if (conflict_clr) begin
            conflict_q <= 1'b0;
            cnt_q      <= '0;
        end else if (collision) begin
            conflict_q <= 1'b1;
            if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign wr_conflict  = conflict_q;
    assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_vliw_regfile.sv
// Directed self-checking bench for vliw_regfile (2 lanes, 2-bit collision counter).
module tb_vliw_regfile;

    localparam int XLEN = 32;

    logic        clk;
    logic        rst;
    logic [9:0]  rs1_addr;
    logic [9:0]  rs2_addr;
    logic [63:0] rs1_data;
    logic [63:0] rs2_data;
    logic [9:0]  wr_addr;
    logic [63:0] wr_data;
    logic [1:0]  wr_en;
    logic        wr_conflict;
    logic [1:0]  conflict_cnt;
    logic        conflict_clr;

    int tests;
    int fails;

    vliw_regfile #(
        .NUM_LANES(2),
        .NUM_REGS (32),
        .XLEN     (XLEN),
        .CNT_W    (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rs1_addr    (rs1_addr),
        .rs2_addr    (rs2_addr),
        .rs1_data    (rs1_data),
        .rs2_data    (rs2_data),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_en       (wr_en),
        .wr_conflict (wr_conflict),
        .conflict_cnt(conflict_cnt),
        .conflict_clr(conflict_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b0;
        rs1_addr = {5'd5, 5'd5};
        rs2_addr = {5'd31, 5'd1};
        wr_addr = '0; wr_data = '0; wr_en = '0; conflict_clr = 1'b0;
        #3;
        tests++;
        if (rs1_data !== 64'd0) begin
            fails++; $display("FAIL reset_rs1: got %h expected 0", rs1_data);
        end
        tests++;
        if (rs2_data !== 64'd0) begin
            fails++; $display("FAIL reset_rs2: got %h expected 0", rs2_data);
        end
        tests++;
        if (wr_conflict !== 1'b0 || conflict_cnt !== 2'd0) begin
            fails++;
            $display("FAIL reset_conflict: got %b/%0d expected 0/0", wr_conflict, conflict_cnt);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_write_read();
        @(negedge clk);
        wr_en = 2'b01; wr_addr = {5'd0, 5'd5}; wr_data = {32'h0, 32'hDEADBEEF};
        @(posedge clk); #1;
        wr_en = 2'b00;
        rs1_addr = {5'd5, 5'd5}; rs2_addr = {5'd5, 5'd5};
        #1;
        tests++;
        if (rs1_data !== {2{32'hDEADBEEF}} || rs2_data !== {2{32'hDEADBEEF}}) begin
            fails++;
            $display("FAIL write_read_x5: got %h %h expected all DEADBEEF", rs1_data, rs2_data);
        end
        @(posedge clk); #1;
        tests++;
        if (rs1_data[31:0] !== 32'hDEADBEEF || rs2_data[63:32] !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL hold_x5: got %h %h expected DEADBEEF", rs1_data[31:0],
                     rs2_data[63:32]);
        end
    endtask

    task automatic test_x0();
        @(negedge clk);
        wr_en = 2'b11; wr_addr = {5'd0, 5'd0}; wr_data = {32'h1234, 32'h9999};
        rs1_addr = {5'd0, 5'd0};
        #1;
        tests++;
        if (rs1_data !== 64'd0) begin
            fails++; $display("FAIL x0_bypass: got %h expected 0", rs1_data);
        end
        @(posedge clk); #1;
        wr_en = 2'b00;
        #1;
        tests++;
        if (rs1_data !== 64'd0) begin
            fails++; $display("FAIL x0_read: got %h expected 0", rs1_data);
        end
        tests++;
        if (wr_conflict !== 1'b0 || conflict_cnt !== 2'd0) begin
            fails++;
            $display("FAIL x0_no_collision: got %b/%0d expected 0/0", wr_conflict, conflict_cnt);
        end
    endtask

    task automatic test_bypass();
        @(negedge clk);
        wr_en = 2'b01; wr_addr = {5'd0, 5'd7}; wr_data = {32'h0, 32'hA5A5A5A5};
        rs2_addr = {5'd7, 5'd0}; rs1_addr = {5'd5, 5'd0};
        #1;
        tests++;
        if (rs2_data[63:32] !== 32'hA5A5A5A5) begin
            fails++; $display("FAIL bypass_x7: got %h expected A5A5A5A5", rs2_data[63:32]);
        end
        tests++;
        if (rs1_data[63:32] !== 32'hDEADBEEF) begin
            fails++; $display("FAIL bypass_other: got %h expected DEADBEEF", rs1_data[63:32]);
        end
        @(posedge clk); #1;
        wr_en = 2'b00;
        #1;
        tests++;
        if (rs2_data[63:32] !== 32'hA5A5A5A5) begin
            fails++; $display("FAIL stored_x7: got %h expected A5A5A5A5", rs2_data[63:32]);
        end
    endtask

    task automatic test_collision();
        @(negedge clk);
        wr_en = 2'b11; wr_addr = {5'd3, 5'd3}; wr_data = {32'h22, 32'h11};
        rs1_addr = {5'd0, 5'd3};
        #1;
        tests++;
        if (rs1_data[31:0] !== 32'h22) begin
            fails++; $display("FAIL collision_bypass: got %h expected 22", rs1_data[31:0]);
        end
        @(posedge clk); #1;
        wr_en = 2'b00;
        #1;
        tests++;
        if (rs1_data[31:0] !== 32'h22) begin
            fails++; $display("FAIL collision_x3: got %h expected 22", rs1_data[31:0]);
        end
        tests++;
        if (wr_conflict !== 1'b1 || conflict_cnt !== 2'd1) begin
            fails++;
            $display("FAIL collision_cnt: got %b/%0d expected 1/1", wr_conflict, conflict_cnt);
        end
        // Different registers on the same edge commit independently, no new collision.
        @(negedge clk);
        wr_en = 2'b11; wr_addr = {5'd11, 5'd10}; wr_data = {32'hBBBB, 32'hAAAA};
        @(posedge clk); #1;
        wr_en = 2'b00;
        rs1_addr = {5'd11, 5'd10};
        #1;
        tests++;
        if (rs1_data !== {32'hBBBB, 32'hAAAA}) begin
            fails++; $display("FAIL independent_writes: got %h expected BBBB/AAAA", rs1_data);
        end
        tests++;
        if (conflict_cnt !== 2'd1) begin
            fails++; $display("FAIL independent_cnt: got %0d expected 1", conflict_cnt);
        end
    endtask

    task automatic test_saturate();
        @(negedge clk);
        conflict_clr = 1'b1;
        @(posedge clk); #1;
        conflict_clr = 1'b0;
        tests++;
        if (wr_conflict !== 1'b0 || conflict_cnt !== 2'd0) begin
            fails++;
            $display("FAIL clear: got %b/%0d expected 0/0", wr_conflict, conflict_cnt);
        end
        @(negedge clk);
        wr_en = 2'b11; wr_addr = {5'd4, 5'd4}; wr_data = {32'h44, 32'h40};
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            if (c == 1) begin
                tests++;
                if (conflict_cnt !== 2'd2) begin
                    fails++; $display("FAIL count_two: got %0d expected 2", conflict_cnt);
                end
            end
        end
        tests++;
        if (conflict_cnt !== 2'd3 || wr_conflict !== 1'b1) begin
            fails++;
            $display("FAIL saturate: got %b/%0d expected 1/3", wr_conflict, conflict_cnt);
        end
        @(negedge clk);
        conflict_clr = 1'b1;
        @(posedge clk); #1;
        conflict_clr = 1'b0;
        wr_en = 2'b00;
        tests++;
        if (wr_conflict !== 1'b0 || conflict_cnt !== 2'd0) begin
            fails++;
            $display("FAIL clear_wins: got %b/%0d expected 0/0", wr_conflict, conflict_cnt);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        wr_en = 2'b10; wr_addr = {5'd9, 5'd0}; wr_data = {32'h55, 32'h0};
        @(posedge clk); #1;
        wr_en = 2'b00;
        rs1_addr = {5'd3, 5'd9};
        #1;
        tests++;
        if (rs1_data[31:0] !== 32'h55) begin
            fails++; $display("FAIL pre_reset_x9: got %h expected 55", rs1_data[31:0]);
        end
        #1;
        rst = 1'b0;
        #1;
        tests++;
        if (rs1_data !== 64'd0) begin
            fails++; $display("FAIL mid_reset_read: got %h expected 0", rs1_data);
        end
        @(negedge clk);
        rst = 1'b1;
        wr_en = 2'b01; wr_addr = {5'd0, 5'd9}; wr_data = {32'h0, 32'h66};
        @(posedge clk); #1;
        wr_en = 2'b00;
        #1;
        tests++;
        if (rs1_data[31:0] !== 32'h66 || rs1_data[63:32] !== 32'h0) begin
            fails++; $display("FAIL post_reset_x9: got %h expected 0/66", rs1_data);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_write_read();
        test_x0();
        test_bypass();
        test_collision();
        test_saturate();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
